iter_divider: RTL and testbench
===============================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 4).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 The block SHALL have port flush  input  1  synchronous abort; drops any in-flight or pending result.
REQ-005 The block SHALL have port in_valid  input  1  request present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at accept.
REQ-008 The block SHALL have port dividend  input  WIDTH  numerator; sampled at accept.
REQ-009 The block SHALL have port divisor  input  WIDTH  denominator; sampled at accept.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port quotient  output  WIDTH  result quotient.
REQ-013 The block SHALL have port remainder  output  WIDTH  result remainder.

Function
REQ-014 The block SHALL implement states IDLE, PREP, CALC, FIX, DONE; exactly one active per cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush; state then goes IDLE->PREP and operands/is_signed are registered.
REQ-017 PREP SHALL record result signs (quotient negative = signed && sign bits differ; remainder negative = signed && dividend negative) and convert signed operands to magnitudes.
REQ-018 PREP SHALL go to DONE directly for divisor==0: quotient = all ones, remainder = original dividend (both modes).
REQ-019 PREP SHALL go to DONE directly for signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): quotient = dividend, remainder = 0.
REQ-020 Otherwise PREP SHALL go to CALC with iteration counter cleared.
REQ-021 CALC SHALL perform one restoring radix-2 step per cycle: shift partial remainder left 1 bringing in next dividend MSB, subtract divisor magnitude, keep the difference and set quotient bit 1 if non-negative, else keep the shifted value and set 0.
REQ-022 CALC SHALL last exactly WIDTH cycles; the counter is clog2(WIDTH)+1 bits wide and never wraps.
REQ-023 FIX SHALL negate quotient and/or remainder magnitudes per REQ-017 signs (two's complement, WIDTH-bit wrap) and go to DONE.
REQ-024 Latency, counting the accept edge as edge 1: DONE entered at edge WIDTH+3 normally; at edge 2 for REQ-018/REQ-019 cases.
REQ-025 In DONE, quotient/remainder SHALL stay constant while out_ready==0; out_valid && out_ready at an edge SHALL move to IDLE.
REQ-026 The block SHALL not accept a new request in the cycle its result is consumed; next accept is at earliest the following edge.
REQ-027 quotient and remainder SHALL be don't-care whenever out_valid==0, except as stated under Reset.
REQ-028 flush==1 at any edge SHALL force IDLE, discarding registered operands and any DONE result; flush overrides in_valid and out_ready in the same cycle.
REQ-029 Input changes while not in IDLE SHALL have no effect on the in-flight operation.

Reset
REQ-030 rst_n==0 at a rising edge SHALL force IDLE, counter 0, quotient 0, remainder 0, out_valid 0, in_ready 1 after that edge.
REQ-031 Reset SHALL take priority over flush and all handshakes, including mid-CALC and in DONE with out_ready low.
REQ-032 After rst_n returns to 1, a request SHALL be acceptable on the first edge.

Verification (WIDTH=32)
REQ-033 Unsigned 100 / 7, out_ready=1 -> out_valid at edge 35, quotient 14, remainder 2, IDLE at edge 36.
REQ-034 Signed 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF.
REQ-035 5 / 0 (either mode) -> out_valid at edge 2, quotient 0xFFFFFFFF, remainder 5; signed 0x80000000 / 0xFFFFFFFF -> edge 2, quotient 0x80000000, remainder 0.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready 0, in_valid ignored; release -> one transfer, IDLE next edge.
REQ-037 Assert flush at CALC cycle 10 -> IDLE next edge, no out_valid; following request 9 / 3 -> quotient 3, remainder 0 at normal latency.
REQ-038 Pull rst_n low for one edge mid-CALC -> out_valid 0, in_ready 1, quotient/remainder 0; no stale result ever emitted.

Source files
------------

// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider, signed or unsigned, one quotient bit per cycle.
// Ports: clk, rst_n (sync, active low), flush, in_valid/in_ready + is_signed/dividend/divisor,
//        out_valid/out_ready + quotient/remainder.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // a_q: dividend, then its magnitude, then quotient bits shifted in from the LSB
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // r_q < b_q always holds, so the difference fits in WIDTH bits when
    // non-negative and bit WIDTH acts as the borrow otherwise.
    assign shifted = {r_q, a_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = PREP;
                    a_d     = dividend;
                    b_d     = divisor;
                    sgn_d   = is_signed;
                end
            end
            PREP: begin
                qneg_d = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d = sgn_q && a_q[WIDTH-1];
                if (b_q == '0) begin
                    quo_d   = '1;
                    rem_d   = a_q;
                    state_d = DONE;
                end else if (sgn_q && (a_q == MIN_NEG) && (b_q == '1)) begin
                    quo_d   = a_q;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    a_d     = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    b_d     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    a_d = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted[WIDTH-1:0];
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = qneg_q ? -a_q : a_q;
                rem_d   = rneg_q ? -r_q : r_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any handshake in the same cycle.
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed testbench for iter_divider (WIDTH=32).
// Each scenario task drives stimulus and checks results inline.
module tb_iter_divider;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    iter_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and clock the accept edge (edge 1), then scramble inputs.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        is_signed = ~s;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0001;
    endtask

    // Returns the edge number (accept = 1) at which out_valid was first seen.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start_op(s, a, b);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        end
        n_checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got q=%h r=%h expected 0/0", quotient, remainder);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat;
        run_op(1'b0, 32'd100, 32'd7, lat);
        n_checks++;
        if (lat !== 35) begin
            n_fail++;
            $display("FAIL u100_7_lat: got %0d expected 35", lat);
        end
        n_checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL u100_7: got q=%h r=%h expected 0000000e/00000002", quotient, remainder);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL u100_7_idle: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, lat);
        tick();
        n_checks++;
        if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF) begin
            n_fail++;
            $display("FAIL uffff_10: got q=%h r=%h expected 0fffffff/0000000f", quotient, remainder);
        end
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        tick();
        n_checks++;
        if (lat !== 35 || quotient !== 32'd0 || remainder !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL u8000_ffff: got lat=%0d q=%h r=%h expected 35 0/80000000",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_signed();
        int lat;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        tick();
        n_checks++;
        if (lat !== 35 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL s_m7_2: got lat=%0d q=%h r=%h expected 35 fffffffd/ffffffff",
                     lat, quotient, remainder);
        end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        tick();
        n_checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL s_7_m2: got q=%h r=%h expected fffffffd/00000001", quotient, remainder);
        end
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
        tick();
        n_checks++;
        if (quotient !== 32'd3 || remainder !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL s_m7_m2: got q=%h r=%h expected 00000003/ffffffff", quotient, remainder);
        end
    endtask

    task automatic test_special();
        int lat;
        run_op(1'b0, 32'd5, 32'd0, lat);
        n_checks++;
        if (lat !== 2 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin
            n_fail++;
            $display("FAIL u5_0: got lat=%0d q=%h r=%h expected 2 ffffffff/00000005",
                     lat, quotient, remainder);
        end
        tick();
        run_op(1'b1, 32'd5, 32'd0, lat);
        n_checks++;
        if (lat !== 2 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5) begin
            n_fail++;
            $display("FAIL s5_0: got lat=%0d q=%h r=%h expected 2 ffffffff/00000005",
                     lat, quotient, remainder);
        end
        tick();
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat);
        n_checks++;
        if (lat !== 2 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFFB) begin
            n_fail++;
            $display("FAIL s_m5_0: got lat=%0d q=%h r=%h expected 2 ffffffff/fffffffb",
                     lat, quotient, remainder);
        end
        tick();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        n_checks++;
        if (lat !== 2 || quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL s_ovf: got lat=%0d q=%h r=%h expected 2 80000000/00000000",
                     lat, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        run_op(1'b0, 32'd20, 32'd6, lat);
        n_checks++;
        if (lat !== 35 || quotient !== 32'd3 || remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d q=%h r=%h expected 35 3/2",
                     lat, quotient, remainder);
        end
        bad = 0;
        in_valid = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                quotient !== 32'd3 || remainder !== 32'd2) begin
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        start_op(1'b0, 32'd1000, 32'd10);
        tick();
        for (int i = 0; i < 9; i++) tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_stale: got %0d valid cycles expected 0", seen);
        end
        run_op(1'b0, 32'd9, 32'd3, lat);
        tick();
        n_checks++;
        if (lat !== 35 || quotient !== 32'd3 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_next: got lat=%0d q=%h r=%h expected 35 3/0",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        start_op(1'b0, 32'd1000, 32'd7);
        for (int i = 0; i < 12; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_calc: got ov=%b ir=%b q=%h r=%h expected 0 1 0 0",
                     out_valid, in_ready, quotient, remainder);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_stale: got %0d valid cycles expected 0", seen);
        end
        out_ready = 1'b0;
        run_op(1'b0, 32'd50, 32'd7, lat);
        rst_n    = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_done: got ov=%b ir=%b q=%h r=%h expected 0 1 0 0",
                     out_valid, in_ready, quotient, remainder);
        end
        out_ready = 1'b1;
        rst_n     = 1'b1;
        run_op(1'b0, 32'd9, 32'd2, lat);
        tick();
        n_checks++;
        if (lat !== 35 || quotient !== 32'd4 || remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_first: got lat=%0d q=%h r=%h expected 35 4/1",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        run_op(1'b0, 32'd45, 32'd4, lat);
        n_checks++;
        if (quotient !== 32'd11 || remainder !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h r=%h expected b/1", quotient, remainder);
        end
        is_signed = 1'b0;
        dividend  = 32'd64;
        divisor   = 32'd8;
        in_valid  = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_noaccept: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
        end
        run_op(1'b0, 32'd64, 32'd8, lat);
        tick();
        n_checks++;
        if (lat !== 35 || quotient !== 32'd8 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h expected 35 8/0",
                     lat, quotient, remainder);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
